// File: rtl/starfield_mixer.sv
// rtl/starfield_mixer.sv - two-stage starfield/foreground/background pixel mixer
// Config registers are CPU-writable at any time; the pixel path only moves on en.
module starfield_mixer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       sf_on,
    input  logic [7:0] sf_star,
    input  logic       fg_on,
    input  logic [7:0] fg_r,
    input  logic [7:0] fg_g,
    input  logic [7:0] fg_b,
    input  logic       write,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hblank_out,
    output logic       vblank_out
);
    logic [7:0] ctrl_q, thresh_q, bg_q, frame_cnt_q;
    logic [2:0] tint_q;
    logic       prev_vblank_q;

    logic       s1_hblank_q, s1_vblank_q, s1_sf_on_q, s1_fg_on_q;
    logic [7:0] s1_star_q, s1_fg_r_q, s1_fg_g_q, s1_fg_b_q;

    logic [7:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic       hblank_out_q, vblank_out_q;

    logic star_en, twinkle_en, stars_behind, twinkle_hit, star_vis;
    logic unused_ctrl;

    assign star_en      = ctrl_q[0];
    assign twinkle_en   = ctrl_q[1];
    assign stars_behind = ctrl_q[2];
    assign unused_ctrl  = ^ctrl_q[7:3];

    // Twinkle phase steps every fourth frame, matched against the star's low bits.
    assign twinkle_hit = twinkle_en && (s1_star_q[2:0] == frame_cnt_q[4:2]);
    assign star_vis    = star_en && s1_sf_on_q && (s1_star_q >= thresh_q) && !twinkle_hit;

    always_comb begin
        r_d = bg_q;
        g_d = bg_q;
        b_d = bg_q;
        if (s1_hblank_q || s1_vblank_q) begin
            r_d = 8'h00;
            g_d = 8'h00;
            b_d = 8'h00;
        end else if (s1_fg_on_q && stars_behind) begin
            r_d = s1_fg_r_q;
            g_d = s1_fg_g_q;
            b_d = s1_fg_b_q;
        end else if (star_vis) begin
            r_d = tint_q[2] ? s1_star_q : 8'h00;
            g_d = tint_q[1] ? s1_star_q : 8'h00;
            b_d = tint_q[0] ? s1_star_q : 8'h00;
        end else if (s1_fg_on_q) begin
            r_d = s1_fg_r_q;
            g_d = s1_fg_g_q;
            b_d = s1_fg_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q        <= 8'h05;
            tint_q        <= 3'b111;
            thresh_q      <= 8'h00;
            bg_q          <= 8'h00;
            frame_cnt_q   <= 8'h00;
            prev_vblank_q <= 1'b0;
            s1_hblank_q   <= 1'b0;
            s1_vblank_q   <= 1'b0;
            s1_sf_on_q    <= 1'b0;
            s1_fg_on_q    <= 1'b0;
            s1_star_q     <= 8'h00;
            s1_fg_r_q     <= 8'h00;
            s1_fg_g_q     <= 8'h00;
            s1_fg_b_q     <= 8'h00;
            r_q           <= 8'h00;
            g_q           <= 8'h00;
            b_q           <= 8'h00;
            hblank_out_q  <= 1'b0;
            vblank_out_q  <= 1'b0;
        end else begin
            if (write) begin
                case (addr)
                    2'd0:    ctrl_q   <= data_in;
                    2'd1:    tint_q   <= data_in[2:0];
                    2'd2:    thresh_q <= data_in;
                    default: bg_q     <= data_in;
                endcase
            end
            if (en) begin
                s1_hblank_q   <= hblank;
                s1_vblank_q   <= vblank;
                s1_sf_on_q    <= sf_on;
                s1_fg_on_q    <= fg_on;
                s1_star_q     <= sf_star;
                s1_fg_r_q     <= fg_r;
                s1_fg_g_q     <= fg_g;
                s1_fg_b_q     <= fg_b;
                r_q           <= r_d;
                g_q           <= g_d;
                b_q           <= b_d;
                hblank_out_q  <= s1_hblank_q;
                vblank_out_q  <= s1_vblank_q;
                prev_vblank_q <= vblank;
                if (vblank && !prev_vblank_q) begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign hblank_out = hblank_out_q;
    assign vblank_out = vblank_out_q;
endmodule

// File: tb/tb_starfield_mixer.sv
// tb/tb_starfield_mixer.sv - directed self-checking bench for starfield_mixer
module tb_starfield_mixer;
    logic       clk = 1'b0;
    logic       rst, en, hblank, vblank, sf_on, fg_on, write;
    logic [7:0] sf_star, fg_r, fg_g, fg_b, data_in;
    logic [1:0] addr;
    logic [7:0] r, g, b;
    logic       hblank_out, vblank_out;
    int         tests = 0;
    int         fails = 0;

    starfield_mixer dut (
        .clk(clk), .rst(rst), .en(en), .hblank(hblank), .vblank(vblank),
        .sf_on(sf_on), .sf_star(sf_star), .fg_on(fg_on),
        .fg_r(fg_r), .fg_g(fg_g), .fg_b(fg_b),
        .write(write), .addr(addr), .data_in(data_in),
        .r(r), .g(g), .b(b), .hblank_out(hblank_out), .vblank_out(vblank_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb, input logic ehb, input logic evb);
        check(tag, {8'h00, r, g, b}, {8'h00, er, eg, eb});
        check({tag, "_blank"}, {30'd0, hblank_out, vblank_out}, {30'd0, ehb, evb});
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        write = 1'b1; addr = a; data_in = d;
        tick();
        write = 1'b0;
    endtask

    task automatic set_fg(input logic on, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        fg_on = on; fg_r = rr; fg_g = gg; fg_b = bb;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; hblank = 1'b0; vblank = 1'b0; sf_on = 1'b0; sf_star = 8'h00;
        write = 1'b0; addr = 2'd0; data_in = 8'h00;
        set_fg(1'b0, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        check_out("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Default white star, two enabled edges of latency
        en = 1'b1; sf_on = 1'b1; sf_star = 8'h80;
        tick();
        check_out("lat1_bg", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        check_out("star_default", 8'h80, 8'h80, 8'h80, 1'b0, 1'b0);

        // Red tint with threshold
        wr(2'd1, 8'h04);
        wr(2'd2, 8'h90);
        tick(); tick();
        check_out("below_thresh", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        sf_star = 8'hA0;
        tick(); tick();
        check_out("red_star", 8'hA0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Foreground vs star priority
        wr(2'd1, 8'h07);
        wr(2'd2, 8'h00);
        sf_star = 8'h55;
        set_fg(1'b1, 8'd10, 8'd20, 8'd30);
        tick(); tick();
        check_out("ctrl5_fg", 8'd10, 8'd20, 8'd30, 1'b0, 1'b0);
        wr(2'd0, 8'h01);
        tick(); tick();
        check_out("ctrl1_star", 8'h55, 8'h55, 8'h55, 1'b0, 1'b0);
        wr(2'd0, 8'h00);
        tick(); tick();
        check_out("ctrl0_fg", 8'd10, 8'd20, 8'd30, 1'b0, 1'b0);

        // Twinkle: four vblank rises -> frame_cnt=4, phase 1
        wr(2'd0, 8'h03);
        wr(2'd3, 8'h33);
        set_fg(1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            vblank = 1'b1; tick();
            vblank = 1'b0; tick();
        end
        sf_star = 8'h81;
        tick(); tick();
        check_out("twinkle_hit", 8'h33, 8'h33, 8'h33, 1'b0, 1'b0);
        sf_star = 8'h82;
        tick(); tick();
        check_out("twinkle_miss", 8'h82, 8'h82, 8'h82, 1'b0, 1'b0);

        // THRESH=255 only passes 255
        wr(2'd0, 8'h01);
        wr(2'd2, 8'hFF);
        sf_star = 8'hFE;
        tick(); tick();
        check_out("thresh_ff_fe", 8'h33, 8'h33, 8'h33, 1'b0, 1'b0);
        sf_star = 8'hFF;
        tick(); tick();
        check_out("thresh_ff_ff", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);

        // hblank wins over foreground
        sf_on = 1'b0; hblank = 1'b1;
        set_fg(1'b1, 8'd10, 8'd20, 8'd30);
        tick(); tick();
        check_out("hblank_fg", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        // en gap freezes outputs, no pixel lost
        hblank = 1'b0;
        set_fg(1'b1, 8'd1, 8'd2, 8'd3);
        tick();
        en = 1'b0;
        set_fg(1'b1, 8'd4, 8'd5, 8'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("frozen", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        end
        en = 1'b1;
        tick();
        check_out("pix_a", 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
        tick();
        check_out("pix_b", 8'd4, 8'd5, 8'd6, 1'b0, 1'b0);

        // Reset overrides pending write and in-flight pixels
        write = 1'b1; addr = 2'd3; data_in = 8'h77; rst = 1'b1;
        tick();
        check_out("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0; write = 1'b0;
        set_fg(1'b0, 8'h00, 8'h00, 8'h00);
        sf_on = 1'b0;
        tick();
        check_out("rst_flush", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        check_out("rst_bg0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        sf_on = 1'b1; sf_star = 8'h10;
        tick(); tick();
        check_out("rst_cfg", 8'h10, 8'h10, 8'h10, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
